// File: rtl/cmos_cap_pkg.sv
// Shared definitions for the DVP RGB565 capture front end.
package cmos_cap_pkg;

   localparam int PIX_W = 16;

   typedef enum logic [1:0] {
      ST_SKIP    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_ACTIVE  = 2'd2
   } cap_state_t;

endpackage

// File: rtl/cmos_sync_edge.sv
// Input register stage for the DVP bus with vsync/href edge detection;
// dat_d is aligned with vs_d/hr_d so edge flags and data refer to the same sample.
module cmos_sync_edge (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vsync,
   input  logic       href,
   input  logic [7:0] data,
   output logic       vs_d,
   output logic       hr_d,
   output logic [7:0] dat_d,
   output logic       vs_rise,
   output logic       vs_fall,
   output logic       hr_fall
);

   logic vs_q;
   logic hr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d  <= 1'b0;
         hr_d  <= 1'b0;
         dat_d <= '0;
         vs_q  <= 1'b0;
         hr_q  <= 1'b0;
      end else begin
         vs_d  <= vsync;
         hr_d  <= href;
         dat_d <= data;
         vs_q  <= vs_d;
         hr_q  <= hr_d;
      end
   end

   always_comb begin
      vs_rise = vs_d & ~vs_q;
      vs_fall = ~vs_d & vs_q;
      hr_fall = ~hr_d & hr_q;
   end

endmodule

// File: rtl/cmos_rgb565_capture.sv
// Camera DVP capture: skips settling frames, packs byte pairs into RGB565
// pixels with x/y coordinates and frame/line markers, all in the pixel clock domain.
module cmos_rgb565_capture
   import cmos_cap_pkg::*;
#(
   parameter int SKIP_FRAMES = 10,
   parameter int XW          = 12,
   parameter int YW          = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmos_vsync,
   input  logic             cmos_href,
   input  logic [7:0]       cmos_data,
   output logic             pix_valid,
   output logic [PIX_W-1:0] pix_data,
   output logic [XW-1:0]    pix_x,
   output logic [YW-1:0]    pix_y,
   output logic             frame_start,
   output logic             frame_end,
   output logic             line_err,
   output logic [7:0]       frame_cnt
);

   localparam int SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
   localparam logic [SKW-1:0] SKIP_TGT = SKW'(SKIP_FRAMES);
   localparam cap_state_t RST_STATE = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;

   logic       vs_d, hr_d, vs_rise, vs_fall, hr_fall;
   logic [7:0] dat_d;

   cmos_sync_edge u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .vsync   (cmos_vsync),
      .href    (cmos_href),
      .data    (cmos_data),
      .vs_d    (vs_d),
      .hr_d    (hr_d),
      .dat_d   (dat_d),
      .vs_rise (vs_rise),
      .vs_fall (vs_fall),
      .hr_fall (hr_fall)
   );

   cap_state_t       state, state_nxt;
   logic [SKW-1:0]   skip_cnt, skip_nxt;
   logic             phase, phase_nxt;
   logic [7:0]       hi_byte, hi_nxt;
   logic             line_pix, line_pix_nxt;
   logic [XW-1:0]    col, col_nxt;
   logic [YW-1:0]    row, row_nxt;
   logic             pv_nxt, fs_nxt, fe_nxt, le_nxt;
   logic [PIX_W-1:0] pd_nxt;
   logic [XW-1:0]    px_nxt;
   logic [YW-1:0]    py_nxt;
   logic [7:0]       fcnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      skip_nxt     = skip_cnt;
      phase_nxt    = phase;
      hi_nxt       = hi_byte;
      line_pix_nxt = line_pix;
      col_nxt      = col;
      row_nxt      = row;
      pv_nxt       = 1'b0;
      pd_nxt       = pix_data;
      px_nxt       = pix_x;
      py_nxt       = pix_y;
      fs_nxt       = 1'b0;
      fe_nxt       = 1'b0;
      le_nxt       = 1'b0;
      fcnt_nxt     = frame_cnt;
      unique case (state)
         ST_SKIP: begin
            if (vs_rise) begin
               skip_nxt = skip_cnt + 1'b1;
               if (skip_nxt == SKIP_TGT) state_nxt = ST_WAIT_VS;
            end
         end
         ST_WAIT_VS: begin
            if (vs_fall) begin
               state_nxt    = ST_ACTIVE;
               fs_nxt       = 1'b1;
               fcnt_nxt     = frame_cnt + 1'b1;
               col_nxt      = '0;
               row_nxt      = '0;
               px_nxt       = '0;
               py_nxt       = '0;
               phase_nxt    = 1'b0;
               line_pix_nxt = 1'b0;
            end
         end
         ST_ACTIVE: begin
            // vsync rising aborts any partial line silently
            if (vs_rise) begin
               state_nxt    = ST_WAIT_VS;
               fe_nxt       = 1'b1;
               phase_nxt    = 1'b0;
               line_pix_nxt = 1'b0;
               col_nxt      = '0;
            end else if (!vs_d) begin
               if (hr_fall) begin
                  le_nxt       = phase;
                  if (line_pix && row != '1) row_nxt = row + 1'b1;
                  col_nxt      = '0;
                  phase_nxt    = 1'b0;
                  line_pix_nxt = 1'b0;
               end else if (hr_d) begin
                  if (!phase) begin
                     hi_nxt    = dat_d;
                     phase_nxt = 1'b1;
                  end else begin
                     pv_nxt       = 1'b1;
                     pd_nxt       = {hi_byte, dat_d};
                     px_nxt       = col;
                     py_nxt       = row;
                     if (col != '1) col_nxt = col + 1'b1;
                     line_pix_nxt = 1'b1;
                     phase_nxt    = 1'b0;
                  end
               end
            end
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_cnt    <= '0;
         phase       <= 1'b0;
         hi_byte     <= '0;
         line_pix    <= 1'b0;
         col         <= '0;
         row         <= '0;
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         line_err    <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         skip_cnt    <= skip_nxt;
         phase       <= phase_nxt;
         hi_byte     <= hi_nxt;
         line_pix    <= line_pix_nxt;
         col         <= col_nxt;
         row         <= row_nxt;
         pix_valid   <= pv_nxt;
         pix_data    <= pd_nxt;
         pix_x       <= px_nxt;
         pix_y       <= py_nxt;
         frame_start <= fs_nxt;
         frame_end   <= fe_nxt;
         line_err    <= le_nxt;
         frame_cnt   <= fcnt_nxt;
      end
   end

endmodule
